// File: rtl/uartprobe_gen2.sv
// Byte-stream debug probe: decodes UART command bytes to access GPI/GPO banks, probe
// registers and single-beat AXI4-Lite reads/writes, and answers with one byte per read.
module uartprobe_gen2 #(
  parameter int unsigned       GPIO_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       TIMEOUT   = 1024,
  parameter logic [GPIO_W-1:0] GPO_RESET = '0
) (
  input  logic                clk,
  input  logic                m_areset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic [GPIO_W-1:0]   gpo,
  input  logic [GPIO_W-1:0]   gpi,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arsize,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awsize,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  localparam int unsigned       STRB_W   = DATA_W / 8;
  localparam logic [2:0]        AXI_SIZE = 3'($clog2(STRB_W));
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(STRB_W);

  typedef enum logic [2:0] {IDLE, GET_ARG, AR, R, W, B, TX} state_e;

  typedef enum logic [3:0] {
    OP_GPI_RD  = 4'h1,
    OP_GPO_RD  = 4'h2,
    OP_GPO_WR  = 4'h3,
    OP_ADDR_RD = 4'h4,
    OP_ADDR_WR = 4'h5,
    OP_DATA_RD = 4'h6,
    OP_DATA_WR = 4'h7,
    OP_AXI_RD  = 4'h8,
    OP_AXI_WR  = 4'h9,
    OP_CTRL_WR = 4'hA,
    OP_CTRL_RD = 4'hB
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [3:0]          idx_q, idx_d;
  logic [GPIO_W-1:0]   gpo_q, gpo_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                auto_inc_q, auto_inc_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;

  logic [7:0] gpi_byte, gpo_byte, addr_byte, data_byte;
  logic       axi_busy, axi_done, aw_left, w_left;
  logic [1:0] axi_resp;

  // Read-side byte selection keyed on the incoming command's index; out-of-range reads stay 0.
  always_comb begin
    gpi_byte  = '0;
    gpo_byte  = '0;
    addr_byte = '0;
    data_byte = '0;
    for (int b = 0; b < int'(GPIO_W / 8); b++) begin
      if (rx_data[3:0] == 4'(b)) begin
        gpi_byte = gpi[b*8 +: 8];
        gpo_byte = gpo_q[b*8 +: 8];
      end
    end
    for (int b = 0; b < int'(ADDR_W / 8); b++) begin
      if (rx_data[3:0] == 4'(b)) addr_byte = addr_q[b*8 +: 8];
    end
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (rx_data[3:0] == 4'(b)) data_byte = data_q[b*8 +: 8];
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    gpo_d      = gpo_q;
    addr_d     = addr_q;
    data_d     = data_q;
    auto_inc_d = auto_inc_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    tmo_cnt_d  = tmo_cnt_q;
    axi_done   = 1'b0;
    axi_resp   = 2'b00;
    aw_left    = 1'b0;
    w_left     = 1'b0;
    axi_busy   = (state_q == AR) || (state_q == R) || (state_q == W) || (state_q == B);

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          op_d       = op_e'(rx_data[7:4]);
          idx_d      = rx_data[3:0];
          state_d    = TX;
          tx_valid_d = 1'b1;
          case (op_e'(rx_data[7:4]))
            OP_GPI_RD:  tx_data_d = gpi_byte;
            OP_GPO_RD:  tx_data_d = gpo_byte;
            OP_ADDR_RD: tx_data_d = addr_byte;
            OP_DATA_RD: tx_data_d = data_byte;
            OP_CTRL_RD: tx_data_d = {7'b0, auto_inc_q};
            OP_GPO_WR, OP_ADDR_WR, OP_DATA_WR, OP_CTRL_WR: begin
              state_d    = GET_ARG;
              tx_valid_d = 1'b0;
            end
            OP_AXI_RD: begin
              state_d    = AR;
              tx_valid_d = 1'b0;
              arvalid_d  = 1'b1;
              tmo_cnt_d  = '0;
            end
            OP_AXI_WR: begin
              state_d    = W;
              tx_valid_d = 1'b0;
              awvalid_d  = 1'b1;
              wvalid_d   = 1'b1;
              tmo_cnt_d  = '0;
            end
            default: tx_data_d = 8'hEE;
          endcase
        end
      end
      GET_ARG: begin
        if (rx_valid) begin
          state_d = IDLE;
          case (op_q)
            OP_GPO_WR: begin
              for (int b = 0; b < int'(GPIO_W / 8); b++)
                if (idx_q == 4'(b)) gpo_d[b*8 +: 8] = rx_data;
            end
            OP_ADDR_WR: begin
              for (int b = 0; b < int'(ADDR_W / 8); b++)
                if (idx_q == 4'(b)) addr_d[b*8 +: 8] = rx_data;
            end
            OP_DATA_WR: begin
              for (int b = 0; b < int'(STRB_W); b++)
                if (idx_q == 4'(b)) data_d[b*8 +: 8] = rx_data;
            end
            OP_CTRL_WR: auto_inc_d = rx_data[0];
            default: ;
          endcase
        end
      end
      AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          data_d   = m_axi_rdata;
          axi_done = 1'b1;
          axi_resp = m_axi_rresp;
        end
      end
      W: begin
        // Address and data channels retire independently; B starts once both have.
        aw_left   = awvalid_q && !m_axi_awready;
        w_left    = wvalid_q && !m_axi_wready;
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = B;
        end
      end
      B: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          axi_done = 1'b1;
          axi_resp = m_axi_bresp;
        end
      end
      TX: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response arriving on the last budgeted cycle still counts as completion.
    if (axi_busy) begin
      if (axi_done) begin
        state_d    = TX;
        tx_valid_d = 1'b1;
        tx_data_d  = {6'b0, axi_resp};
        if (axi_resp == 2'b00 && auto_inc_q) addr_d = addr_q + ADDR_INC;
      end else if (tmo_cnt_q == CNT_LAST) begin
        state_d    = TX;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h80;
        data_d     = data_q;
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        bready_d   = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (m_areset) begin
      state_q    <= IDLE;
      op_q       <= OP_GPI_RD;
      idx_q      <= '0;
      gpo_q      <= GPO_RESET;
      addr_q     <= '0;
      data_q     <= '0;
      auto_inc_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      gpo_q      <= gpo_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      auto_inc_q <= auto_inc_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign rx_ready      = (state_q == IDLE) || (state_q == GET_ARG);
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign gpo           = gpo_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: doc/uartprobe_gen2.md
Name: uartprobe_gen2

Overview:
- Parametrised successor to the byte-stream debug probe. Decodes command bytes from a UART RX byte stream and drives/reads GPO/GPI banks of configurable width.
- Issues single-beat AXI4-Lite-style reads and writes of configurable width, with optional address auto-increment and a response timeout.
- Returns one status or data byte per read/AXI command on the UART TX byte stream.
- Sits between the UART byte layer and the SoC AXI fabric.

Parameters:
GPIO_W, 32, GPI/GPO width in bits; multiple of 8, max 128
ADDR_W, 32, AXI address width; multiple of 8, max 128
DATA_W, 32, AXI data width; 8/16/32/64
TIMEOUT, 1024, cycles allowed per AXI transaction before abort; >= 2
GPO_RESET, 0, reset value of gpo

Ports:
clk  in  1  clock, all logic on rising edge
m_areset  in  1  synchronous active-high reset
rx_valid  in  1  command byte valid
rx_data  in  8  command/argument byte
rx_ready  out  1  probe accepts rx byte
tx_valid  out  1  response byte valid
tx_data  out  8  response byte
tx_ready  in  1  UART accepts tx byte
gpo  out  GPIO_W  general purpose outputs
gpi  in  GPIO_W  general purpose inputs
m_axi_araddr  out  ADDR_W  read address
m_axi_arsize  out  3  log2(DATA_W/8), constant
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
m_axi_awaddr  out  ADDR_W  write address
m_axi_awsize  out  3  log2(DATA_W/8), constant
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_W  write data
m_axi_wstrb  out  DATA_W/8  all ones
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready

Behaviour:
- Reset: clk is the only clock. m_areset is synchronous and active-high. It forces state IDLE, gpo=GPO_RESET, addr/data/ctrl registers=0, and all valid/ready outputs=0, including in mid-transaction.
- Byte transfer: a byte moves on a rising edge with valid&ready high. rx_ready=1 only in IDLE and GET_ARG. tx_valid holds with tx_data stable until tx_ready; then the block returns to IDLE on the next cycle.
- Command byte {op[7:4], idx[3:0]}. Byte index 0 = LSB.
  - op1 GPI_RD idx: tx gpi byte idx, sampled on the accept cycle.
  - op2 GPO_RD idx: tx gpo byte idx.
  - op3 GPO_WR idx: the next rx byte is written to gpo byte idx. No tx.
  - op4 ADDR_RD idx / op5 ADDR_WR idx: same pattern on the ADDR_W address register.
  - op6 DATA_RD idx / op7 DATA_WR idx: same pattern on the DATA_W data register.
  - opA CTRL_WR: the next rx byte is written to ctrl; only ctrl[0]=auto-increment is used.
  - opB CTRL_RD: tx {7'b0, ctrl[0]}.
  - op8 AXI_RD: issue a read at addr; on R, data register <= rdata; tx status.
  - op9 AXI_WR: write data register to addr; tx status.
  - Any other op: tx 0xEE. If idx is out of range for the target width, reads tx 0x00 and writes are discarded. The argument byte is still consumed.
- States: IDLE, GET_ARG, AR, R, W (AW/W), B, TX.
  - AR: arvalid=1 until arready. R: rready=1 until rvalid.
  - W: awvalid and wvalid are asserted together and each drops independently on its own handshake. Exit to B when both are done.
  - B: bready=1 until bvalid.
  - Status byte = {timeout, 5'b0, resp[1:0]}.
- Timeout: a counter starts on entry to AR/W. If TIMEOUT cycles elapse before R/B completes, drop all AXI valid/ready outputs and tx status 0x80. The data register and addr are not changed.
- Auto-increment: on successful completion (resp=00) with ctrl[0]=1, addr += DATA_W/8, modulo 2^ADDR_W (wraps to 0).
- Fixed AXI fields: m_axi_arsize and m_axi_awsize are constant. m_axi_araddr and m_axi_awaddr both equal the address register.

Test Plan:
- Reset with GPO_RESET=32'hA5A5_0000, then cmd 0x22 -> tx 0xA5. Assert m_areset while in R -> rready=0 and state IDLE on the next cycle.
- gpi=32'h1234_5678: cmds 0x10, 0x13, 0x1F -> tx 0x78, 0x12, 0x00.
- Cmd 0x31 then 0xC3 -> gpo=32'h0000_C300. Cmd 0x21 -> tx 0xC3.
- Set addr=32'hFFFF_FFFC via 0x50–0x53, ctrl=0x01, data=32'hDEAD_BEEF. Cmd 0x90 with bresp=00 -> awaddr=FFFF_FFFC, wdata=DEADBEEF, wstrb=F, tx 0x00, addr wraps to 0.
- Cmd 0x80 with rdata=32'hCAFE_F00D, rresp=2 -> tx 0x02, addr unchanged. Cmds 0x60–0x63 -> tx 0D, F0, FE, CA.
- Cmd 0x80 with arready held 0 -> arvalid drops after TIMEOUT cycles, tx 0x80. Cmd 0xF0 -> tx 0xEE.
